// File: rtl/g2x_rr_sched_if.sv
// Two-port bcnt/data FIFO read side plus the merged XGMII-style output stream.
interface g2x_rr_sched_if;
    logic        sched_en;
    logic [1:0]  bcnt_empty;
    logic [15:0] bcnt_in0;
    logic [15:0] bcnt_in1;
    logic [63:0] data_in0;
    logic [63:0] data_in1;
    logic [7:0]  ctrl_in0;
    logic [7:0]  ctrl_in1;
    logic [1:0]  bcnt_re;
    logic [1:0]  data_re;
    logic [1:0]  grant;
    logic [63:0] data_out;
    logic [7:0]  ctrl_out;

    modport master (
        output sched_en, bcnt_empty, bcnt_in0, bcnt_in1,
               data_in0, data_in1, ctrl_in0, ctrl_in1,
        input  bcnt_re, data_re, grant, data_out, ctrl_out
    );

    modport slave (
        input  sched_en, bcnt_empty, bcnt_in0, bcnt_in1,
               data_in0, data_in1, ctrl_in0, ctrl_in1,
        output bcnt_re, data_re, grant, data_out, ctrl_out
    );
endinterface

// File: rtl/g2x_rr_sched.sv
// Round-robin packet scheduler merging two bcnt/data FIFO pairs into one
// 64-bit stream, with a fixed inter-packet gap after every packet.
module g2x_rr_sched #(
    parameter int IPG_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset_,
    g2x_rr_sched_if.slave  bus
);
    localparam logic [63:0] IDLE_DATA = 64'h0707070707070707;
    localparam logic [7:0]  IDLE_CTRL = 8'hFF;

    typedef enum logic [4:0] {
        IDLE     = 5'b00001,
        RD_BCNT  = 5'b00010,
        BCNT_BUF = 5'b00100,
        RD_DATA  = 5'b01000,
        IPG      = 5'b10000
    } state_t;

    state_t      state, state_nxt;
    logic        sel, last, pick, start, ipg_done;
    logic        sel_dly1, data_re_dly1;
    logic [1:0]  req;
    logic [15:0] bcnt_cur;
    logic [13:0] qwd_cnt, qwd_load;
    logic [3:0]  ipg_cnt;

    assign req      = ~bus.bcnt_empty;
    // Prefer the port not granted last; a lone requester falls through to itself.
    assign pick     = req[~last] ? ~last : last;
    assign start    = bus.sched_en && (|req);
    assign bcnt_cur = sel ? bus.bcnt_in1 : bus.bcnt_in0;
    assign qwd_load = {1'b0, bcnt_cur[15:3]} + {13'd0, |bcnt_cur[2:0]};
    assign ipg_done = (ipg_cnt == 4'(IPG_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bus.bcnt_re = 2'b00;
        bus.data_re = 2'b00;
        bus.grant   = 2'b00;
        case (state)
            IDLE:     if (start) state_nxt = RD_BCNT;
            RD_BCNT: begin
                bus.bcnt_re[sel] = 1'b1;
                state_nxt        = BCNT_BUF;
            end
            // bcnt_in is valid here (1-cycle FIFO latency); zero-length packets skip the read.
            BCNT_BUF: state_nxt = (qwd_load != 14'd0) ? RD_DATA : IPG;
            RD_DATA: begin
                bus.data_re[sel] = 1'b1;
                if (qwd_cnt == 14'd1) state_nxt = IPG;
            end
            IPG:      if (ipg_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (state != IDLE) bus.grant[sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sel     <= 1'b0;
            last    <= 1'b1;
            qwd_cnt <= 14'd0;
            ipg_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE:     if (start) sel <= pick;
                BCNT_BUF: qwd_cnt <= qwd_load;
                RD_DATA:  qwd_cnt <= qwd_cnt - 14'd1;
                IPG: begin
                    ipg_cnt <= ipg_done ? 4'd0 : ipg_cnt + 4'd1;
                    if (ipg_done) last <= sel;
                end
                default: ;
            endcase
        end
    end

    // Data FIFO has 1-cycle read latency, so the mux follows the delayed read/select.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            data_re_dly1 <= 1'b0;
            sel_dly1     <= 1'b0;
            bus.data_out <= IDLE_DATA;
            bus.ctrl_out <= IDLE_CTRL;
        end else begin
            data_re_dly1 <= |bus.data_re;
            sel_dly1     <= sel;
            if (data_re_dly1) begin
                bus.data_out <= sel_dly1 ? bus.data_in1 : bus.data_in0;
                bus.ctrl_out <= sel_dly1 ? bus.ctrl_in1 : bus.ctrl_in0;
            end else begin
                bus.data_out <= IDLE_DATA;
                bus.ctrl_out <= IDLE_CTRL;
            end
        end
    end
endmodule

// File: doc/g2x_rr_sched.md
G2X_RR_SCHED -- requirements
Module: g2x_rr_sched

Interface
REQ-001 SHALL provide parameter IPG_CYCLES, default 2, meaning the number of idle cycles inserted after each packet (legal range 1-15).
REQ-002 SHALL provide port clk, input, 1, the single clock; all flops are clocked on its rising edge.
REQ-003 SHALL provide port reset_, input, 1, asynchronous active-low reset.
REQ-004 SHALL provide port sched_en, input, 1; when high, new packets may be granted.
REQ-005 SHALL provide port bcnt_empty, input, 2; bit n high means the bcnt FIFO of port n is empty.
REQ-006 SHALL provide ports bcnt_in0 and bcnt_in1, input, 16 each; packet byte count from the port 0 and port 1 bcnt FIFOs.
REQ-007 SHALL provide ports data_in0 and data_in1, input, 64 each, and ctrl_in0 and ctrl_in1, input, 8 each; data FIFO outputs for each port.
REQ-008 SHALL provide port bcnt_re, output, 2; bcnt FIFO read enable, one bit per port.
REQ-009 SHALL provide port data_re, output, 2; data FIFO read enable, one bit per port.
REQ-010 SHALL provide port data_out, output, 64, and port ctrl_out, output, 8; the merged XGMII-style stream.
REQ-011 SHALL provide port grant, output, 2; one-hot port currently owning the stream, 2'b00 when none owns it.

Function
REQ-012 SHALL implement a one-hot state machine with states IDLE, RD_BCNT, BCNT_BUF, RD_DATA and IPG.
REQ-013 In IDLE, the block SHALL select a port when sched_en=1 and any bcnt_empty bit is 0, moving to RD_BCNT, setting grant and asserting bcnt_re[sel] for exactly the RD_BCNT cycle; otherwise it SHALL remain in IDLE.
REQ-014 Port selection SHALL be round-robin: priority goes to the port not granted last, and a lone requester SHALL always win.
REQ-015 RD_BCNT SHALL always advance to BCNT_BUF, where the block SHALL capture bcnt_in of the selected port, since the FIFO has a 1-cycle read latency.
REQ-016 In BCNT_BUF, the block SHALL load a 14-bit qwd_cnt with bcnt[15:3] + |bcnt[2:0] (so 16'hFFFF yields 8192).
REQ-017 From BCNT_BUF, if qwd_cnt is nonzero the block SHALL enter RD_DATA with data_re[sel]=1; if it is zero the block SHALL enter IPG with no data read (empty-packet drop).
REQ-018 In RD_DATA, data_re[sel] SHALL remain high for exactly qwd_cnt consecutive cycles with the count decrementing each cycle; on the last read the block SHALL deassert data_re and enter IPG.
REQ-019 IPG SHALL last exactly IPG_CYCLES cycles, after which the block SHALL clear grant, record the last-granted port and return to IDLE.
REQ-020 data_re and the selected-port index SHALL each be delayed by one register (dly1).
REQ-021 data_out and ctrl_out SHALL be registered from the dly1-selected port's data_in and ctrl_in when data_re_dly1=1; otherwise they SHALL be 64'h0707070707070707 and 8'hFF.
REQ-022 The first data word SHALL appear on data_out 2 cycles after the first data_re cycle.
REQ-023 Only one bit of bcnt_re, of data_re and of grant SHALL be high at any time, and bcnt_re and data_re SHALL never be high in the same cycle.
REQ-024 Deasserting sched_en mid-packet SHALL NOT abort the packet; it SHALL only block the next grant from IDLE.
REQ-025 A change in bcnt_empty outside IDLE SHALL be ignored until the block returns to IDLE.

Reset
REQ-026 While reset_=0, regardless of clk, the block SHALL force state=IDLE, bcnt_re=0, data_re=0, grant=0, qwd_cnt=0, IPG counter=0, all dly1 registers=0, last-granted=port 1 (so port 0 wins first), data_out=64'h0707070707070707 and ctrl_out=8'hFF.
REQ-027 Reset asserted mid-packet SHALL abandon the packet with no completion; after release the block SHALL restart from IDLE.

Verification
REQ-028 Port 0 only, bcnt=64 -> bcnt_re[0] pulses 1 cycle, data_re[0] high 8 cycles, data_out carries 8 words starting 2 cycles after the first data_re, then 2 idle cycles before IDLE.
REQ-029 Both ports request with bcnt=9 each -> port 0 reads 2 words, then port 1 reads 2 words; grant sequence is 01, 00, 10.
REQ-030 bcnt=0 on port 1 -> no data_re, block passes BCNT_BUF then IPG, and the stream stays 0707.../FF.
REQ-031 bcnt=16'hFFFF -> data_re high for exactly 8192 cycles.
REQ-032 sched_en dropped during RD_DATA of a 4-word packet -> all 4 words are output, then the block holds in IDLE despite bcnt_empty=2'b00 until sched_en returns to 1.
REQ-033 reset_ pulsed low mid RD_DATA without a clk edge -> outputs go immediately to their REQ-026 values, and after release port 0 wins the next grant.
